alu_serial: RTL
===============

ALU_SERIAL -- requirements
Module: alu_serial

Interface
REQ-001 Parameter DATA_W, default 8, operand/result width in bits; SHALL be >= 8.
REQ-002 Parameter SLICE_W, default 4, bits processed per clock; SHALL divide DATA_W exactly; NSLICE = DATA_W/SLICE_W.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request; sampled only while idle.
REQ-006 alu_op  input  3  0 add, 1 adc, 2 sub, 3 sbc, 4 and, 5 xor, 6 or, 7 cp.
REQ-007 in_A  input  DATA_W  first operand.
REQ-008 in_B  input  DATA_W  second operand.
REQ-009 in_C  input  1  carry/borrow in; used by adc/sbc only.
REQ-010 busy  output  1  high while an operation is in progress.
REQ-011 done  output  1  one-cycle pulse; out/out_flags valid.
REQ-012 out  output  DATA_W  result, held until the next done.
REQ-013 out_flags  output  4  {Z, N, H, C}, held with out.

Function
REQ-014 States IDLE, RUN, DONE; IDLE -> RUN on start; RUN -> DONE after slice NSLICE-1; DONE -> IDLE unconditionally.
REQ-015 On IDLE with start=1, the block SHALL latch in_A, in_B, alu_op, in_C and clear the slice counter; later input changes SHALL NOT affect the operation.
REQ-016 In RUN, slice k (LSB slice first, k = 0..NSLICE-1) SHALL be computed each cycle, with carry/borrow chained from slice k-1 via an internal register.
REQ-017 Slice 0 carry-in SHALL be 0 for add, sub, cp; the latched in_C for adc, sbc; unused for logic ops.
REQ-018 Latency: start sampled at edge 0 -> done=1 in the cycle after edge NSLICE+1 (NSLICE RUN cycles + 1 DONE cycle); busy=1 from edge 1 until the edge that enters IDLE.
REQ-019 start while busy=1 SHALL be ignored; no queuing.
REQ-020 Arithmetic modulo 2^DATA_W; sub/sbc/cp compute A - B - cin.
REQ-021 out = computed result for ops 0-6; for cp, out = latched in_A unchanged.
REQ-022 Z = 1 iff the full-width computed result (subtraction result for cp) is zero.
REQ-023 N = 1 for sub, sbc, cp; 0 otherwise.
REQ-024 H = carry out of bit 3 (add/adc) or borrow from bit 4 (sub/sbc/cp); 1 for and; 0 for xor, or.
REQ-025 C = carry out of MSB (add/adc) or borrow out of MSB (sub/sbc/cp); 0 for logic ops.
REQ-026 H SHALL be correct for any SLICE_W, including slices straddling bit 3.
REQ-027 out and out_flags SHALL update only at the edge that enters DONE, and hold otherwise.

Reset
REQ-028 reset=1 SHALL immediately force IDLE, busy=0, done=0, out=0, out_flags=0, clear all internal slice/carry registers.
REQ-029 Reset asserted mid-operation SHALL abort it; no done pulse follows; next start after reset release starts a fresh operation.

Verification
REQ-030 DATA_W=8, SLICE_W=4: add 0x3A+0xC6 -> done at cycle 3, out=0x00, flags Z1 N0 H1 C1.
REQ-031 sbc 0x00-0x00, in_C=1 -> out=0xFF, flags Z0 N1 H1 C1; sub 0x10-0x01 -> 0x0F, Z0 N1 H1 C0.
REQ-032 cp 0x42 vs 0x42 -> out=0x42, flags Z1 N1 H0 C0; and 0xF0&0x0F -> 0x00, Z1 N0 H1 C0.
REQ-033 DATA_W=16, SLICE_W=1: adc 0x0FFF+0xF000, in_C=1 -> done after 17 cycles, out=0x0000, Z1 N0 H1 C1.
REQ-034 start pulsed during busy, in_A changed mid-op -> result unchanged, exactly one done pulse.
REQ-035 reset asserted at RUN slice 1 -> busy=0, out=0 immediately, no done; following add 0x01+0x01 -> 0x02, flags 0.

Source files
------------

// File: rtl/alu_serial.sv
// Slice-serial 8-op ALU: processes SLICE_W bits per clock, LSB slice first.
// Flags {Z,N,H,C} and result are registered when the last slice completes.
module alu_serial #(
  parameter int DATA_W  = 8,
  parameter int SLICE_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] in_A,
  input  logic [DATA_W-1:0] in_B,
  input  logic              in_C,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] out,
  output logic [3:0]        out_flags
);

  localparam int NSLICE = DATA_W / SLICE_W;
  localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [2:0] {
    OP_ADD, OP_ADC, OP_SUB, OP_SBC,
    OP_AND, OP_XOR, OP_OR, OP_CP
  } op_t;

  state_t            state;
  op_t               op_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] res_q;
  logic              carry_q;
  logic [CW-1:0]     cnt;

  logic [31:0]        sh;
  logic [SLICE_W-1:0] s_a;
  logic [SLICE_W-1:0] s_b;
  logic [SLICE_W-1:0] s_res;
  logic [SLICE_W:0]   ext;
  logic               s_cout;
  logic [DATA_W-1:0]  res_full;
  logic               is_sub;
  logic               is_arith;
  logic               h_flag;
  logic               last;

  always_comb begin
    sh     = 32'(cnt) * 32'(SLICE_W);
    s_a    = SLICE_W'(a_q >> sh);
    s_b    = SLICE_W'(b_q >> sh);
    ext    = '0;
    s_res  = '0;
    s_cout = 1'b0;
    unique case (op_q)
      OP_ADD, OP_ADC: begin
        ext    = {1'b0, s_a} + {1'b0, s_b}
               + (SLICE_W+1)'(carry_q);
        s_res  = ext[SLICE_W-1:0];
        s_cout = ext[SLICE_W];
      end
      OP_SUB, OP_SBC, OP_CP: begin
        ext    = {1'b0, s_a} - {1'b0, s_b}
               - (SLICE_W+1)'(carry_q);
        s_res  = ext[SLICE_W-1:0];
        s_cout = ext[SLICE_W];
      end
      OP_AND: s_res = s_a & s_b;
      OP_XOR: s_res = s_a ^ s_b;
      OP_OR:  s_res = s_a | s_b;
      default: s_res = '0;
    endcase
    // result shifts in from the top; aligned after NSLICE slices
    res_full = (res_q >> SLICE_W)
             | (DATA_W'(s_res) << (DATA_W - SLICE_W));
    is_sub   = (op_q == OP_SUB) || (op_q == OP_SBC)
            || (op_q == OP_CP);
    is_arith = is_sub || (op_q == OP_ADD) || (op_q == OP_ADC);
    // carry/borrow into bit 4 recovered from the full-width sum
    h_flag   = res_full[4] ^ a_q[4] ^ b_q[4];
    last     = (cnt == CW'(NSLICE - 1));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      op_q      <= OP_ADD;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      carry_q   <= 1'b0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out       <= '0;
      out_flags <= '0;
    end else begin
      busy <= (state == RUN);
      done <= (state == DONE);
      unique case (state)
        IDLE: begin
          if (start) begin
            a_q     <= in_A;
            b_q     <= in_B;
            op_q    <= op_t'(alu_op);
            carry_q <= ((alu_op == 3'd1) || (alu_op == 3'd3))
                     ? in_C : 1'b0;
            cnt     <= '0;
            res_q   <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          res_q   <= res_full;
          carry_q <= s_cout;
          cnt     <= cnt + 1'b1;
          if (last) begin
            state        <= DONE;
            out          <= (op_q == OP_CP) ? a_q : res_full;
            out_flags[3] <= (res_full == '0);
            out_flags[2] <= is_sub;
            out_flags[1] <= is_arith ? h_flag : (op_q == OP_AND);
            out_flags[0] <= is_arith & s_cout;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
